// File: rtl/boot_loader.sv
// boot_loader: receives a framed, checksummed program image into RAM, then releases the CPU and passes its memory bus through
module boot_loader #(
  parameter int RAM_SIZE_LOG = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic [15:0] cpu_addr_i,
  input  logic [15:0] cpu_data_i,
  input  logic        cpu_we_i,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_data_o,
  output logic        mem_we_o,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        err_o
);
  localparam int IW = RAM_SIZE_LOG + 1;
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHECK, RUN, ERROR} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0] n_q, n_d;
  logic [7:0] sum_q, sum_d, lo_q, lo_d, hi_q, hi_d;
  logic cpu_rst_q, done_q, err_q;
  logic ready_st, acc;
  logic [15:0] n_full;
  assign ready_st = state_q != WRITE && state_q != RUN && state_q != ERROR;
  assign rx_ready_o = ready_st && !rst_i;
  assign acc = rx_valid_i && ready_st;
  assign n_full = {rx_data_i, n_q[7:0]};
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    n_d = n_q;
    lo_d = lo_q;
    hi_d = hi_q;
    sum_d = acc ? sum_q ^ rx_data_i : sum_q;
    case (state_q)
      LEN_LO: if (acc) begin
        n_d[7:0] = rx_data_i;
        state_d = LEN_HI;
      end
      LEN_HI: if (acc) begin
        n_d[15:8] = rx_data_i;
        state_d = ({1'b0, n_full} > (17'(1) << RAM_SIZE_LOG)) ? ERROR : (n_full == 16'd0) ? CHECK : DATA_LO;
      end
      DATA_LO: if (acc) begin
        lo_d = rx_data_i;
        state_d = DATA_HI;
      end
      DATA_HI: if (acc) begin
        hi_d = rx_data_i;
        state_d = WRITE;
      end
      WRITE: begin
        idx_d = idx_q + 1'b1;
        state_d = (16'(idx_q) + 16'd1 == n_q) ? CHECK : DATA_LO;
      end
      CHECK: if (acc) state_d = (rx_data_i == sum_q) ? RUN : ERROR;
      default: ;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= LEN_LO;
      idx_q <= '0;
      n_q <= '0;
      sum_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      cpu_rst_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      n_q <= n_d;
      sum_q <= sum_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      cpu_rst_q <= state_d != RUN;
      done_q <= state_d == RUN;
      err_q <= state_d == ERROR;
    end
  end
  // Once running the loader is invisible; before that the CPU side is ignored.
  assign mem_we_o = (state_q == RUN) ? cpu_we_i : (state_q == WRITE);
  assign mem_addr_o = (state_q == RUN) ? cpu_addr_i : (state_q == ERROR) ? 16'd0 : 16'(idx_q);
  assign mem_data_o = (state_q == RUN) ? cpu_data_i : {hi_q, lo_q};
  assign cpu_rst_o = cpu_rst_q;
  assign done_o = done_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed frames against boot_loader with hand-computed expectations
module tb_boot_loader;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [7:0] rx_data_i = '0;
  logic rx_valid_i = 1'b0;
  logic rx_ready_o;
  logic [15:0] cpu_addr_i = '0, cpu_data_i = '0;
  logic cpu_we_i = 1'b0;
  logic [15:0] mem_addr_o, mem_data_o;
  logic mem_we_o, cpu_rst_o, done_o, err_o;
  int checks = 0, errors = 0, acc_cnt = 0;
  logic [15:0] wa[$], wd[$];

  boot_loader #(.RAM_SIZE_LOG(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_we_i(cpu_we_i), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_we_o(mem_we_o), .cpu_rst_o(cpu_rst_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (mem_we_o && cpu_rst_o) begin
    wa.push_back(mem_addr_o);
    wd.push_back(mem_data_o);
  end

  always @(posedge clk_i) if (rx_valid_i && rx_ready_o) acc_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rx_valid_i = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    wa.delete();
    wd.delete();
    acc_cnt = 0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    rx_data_i = b;
    rx_valid_i = 1'b1;
    @(negedge clk_i);
    while (!rx_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!rx_ready_o) chk("ready_timeout", {31'd0, rx_ready_o}, 1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] cs);
    logic [7:0] f[8] = '{8'h03, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    foreach (f[i]) push(f[i]);
    push(cs);
  endtask

  task automatic chk_writes3(input string tag);
    chk({tag, "_nwr"}, wa.size(), 3);
    if (wa.size() == 3) begin
      chk({tag, "_a0"}, wa[0], 16'h0000);
      chk({tag, "_d0"}, wd[0], 16'h1234);
      chk({tag, "_a1"}, wa[1], 16'h0001);
      chk({tag, "_d1"}, wd[1], 16'h5678);
      chk({tag, "_a2"}, wa[2], 16'h0002);
      chk({tag, "_d2"}, wd[2], 16'h9ABC);
    end
  endtask

  initial begin
    do_reset();
    chk("rst_cpu_rst", {31'd0, cpu_rst_o}, 1);
    chk("rst_done", {31'd0, done_o}, 0);
    chk("rst_err", {31'd0, err_o}, 0);
    chk("rst_we", {31'd0, mem_we_o}, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_data", mem_data_o, 0);
    chk("rst_ready", {31'd0, rx_ready_o}, 1);

    push_frame(8'h2D);
    chk("ok_done", {31'd0, done_o}, 1);
    chk("ok_cpu_rst", {31'd0, cpu_rst_o}, 0);
    chk("ok_err", {31'd0, err_o}, 0);
    chk("ok_ready", {31'd0, rx_ready_o}, 0);
    chk_writes3("ok");
    cpu_addr_i = 16'h0005;
    cpu_data_i = 16'hBEEF;
    cpu_we_i = 1'b1;
    #1;
    chk("run_addr", mem_addr_o, 16'h0005);
    chk("run_data", mem_data_o, 16'hBEEF);
    chk("run_we", {31'd0, mem_we_o}, 1);
    cpu_we_i = 1'b0;
    #1;
    chk("run_we0", {31'd0, mem_we_o}, 0);

    do_reset();
    cpu_we_i = 1'b1;
    push_frame(8'h2C);
    chk("bad_err", {31'd0, err_o}, 1);
    chk("bad_cpu_rst", {31'd0, cpu_rst_o}, 1);
    chk("bad_done", {31'd0, done_o}, 0);
    chk("bad_ready", {31'd0, rx_ready_o}, 0);
    chk("bad_we", {31'd0, mem_we_o}, 0);
    chk("bad_addr", mem_addr_o, 0);
    chk_writes3("bad");
    acc_cnt = 0;
    rx_data_i = 8'h55;
    repeat (5) @(posedge clk_i);
    #1;
    chk("bad_more_nwr", wa.size(), 3);
    chk("bad_more_acc", acc_cnt, 0);
    chk("bad_more_err", {31'd0, err_o}, 1);
    cpu_we_i = 1'b0;

    do_reset();
    push(8'h00);
    push(8'h00);
    chk("empty_done_early", {31'd0, done_o}, 0);
    push(8'h00);
    chk("empty_done", {31'd0, done_o}, 1);
    chk("empty_cpu_rst", {31'd0, cpu_rst_o}, 0);
    chk("empty_nwr", wa.size(), 0);

    do_reset();
    push(8'h01);
    chk("big_err_early", {31'd0, err_o}, 0);
    push(8'h01);
    chk("big_err", {31'd0, err_o}, 1);
    chk("big_done", {31'd0, done_o}, 0);
    chk("big_ready", {31'd0, rx_ready_o}, 0);
    chk("big_nwr", wa.size(), 0);

    do_reset();
    push(8'h01);
    push(8'h00);
    push(8'hAA);
    push(8'h55);
    chk("bp_ready_write", {31'd0, rx_ready_o}, 0);
    chk("bp_we_write", {31'd0, mem_we_o}, 1);
    push(8'hFE);
    chk("bp_done", {31'd0, done_o}, 1);
    chk("bp_acc", acc_cnt, 5);
    chk("bp_nwr", wa.size(), 1);
    if (wa.size() == 1) chk("bp_d0", wd[0], 16'h55AA);

    do_reset();
    push(8'h03);
    push(8'h00);
    push(8'h34);
    push(8'h12);
    push(8'h78);
    chk("mid_addr_pre", mem_addr_o, 16'h0001);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_cpu_rst", {31'd0, cpu_rst_o}, 1);
    chk("mid_addr", mem_addr_o, 0);
    chk("mid_data", mem_data_o, 0);
    chk("mid_we", {31'd0, mem_we_o}, 0);
    chk("mid_done", {31'd0, done_o}, 0);
    chk("mid_err", {31'd0, err_o}, 0);
    do_reset();
    push_frame(8'h2D);
    chk("mid_replay_done", {31'd0, done_o}, 1);
    chk_writes3("mid_replay");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
